// File: rtl/lcd_text_pkg.sv
// rtl/lcd_text_pkg.sv - shared types and constants for the LCD text buffer
package lcd_text_pkg;

  // Sequencer states: IDLE accepts input, CLEAR/SCROLL walk the cell array
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } lcd_state_e;

  // Classification of an incoming character
  typedef enum logic [2:0] {
    CC_IGNORE = 3'd0,
    CC_PRINT  = 3'd1,
    CC_LF     = 3'd2,
    CC_CR     = 3'd3,
    CC_BS     = 3'd4,
    CC_FF     = 3'd5
  } char_class_e;

  localparam logic [7:0] CHR_BS = 8'h08;
  localparam logic [7:0] CHR_LF = 8'h0A;
  localparam logic [7:0] CHR_FF = 8'h0C;
  localparam logic [7:0] CHR_CR = 8'h0D;

  localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;

endpackage

// File: rtl/lcd_char_decode.sv
// rtl/lcd_char_decode.sv - classifies an incoming byte as printable, control or ignored
module lcd_char_decode
  import lcd_text_pkg::*;
(
  input  logic [7:0]  char_in,
  output char_class_e char_class
);

  // Printable ranges follow the SC1602 character ROM (ASCII plus katakana block)
  always_comb begin
    char_class = CC_IGNORE;
    if ((char_in >= 8'h20 && char_in <= 8'h7E) ||
        (char_in >= 8'hA0 && char_in <= 8'hDF)) begin
      char_class = CC_PRINT;
    end else begin
      case (char_in)
        CHR_LF:  char_class = CC_LF;
        CHR_CR:  char_class = CC_CR;
        CHR_BS:  char_class = CC_BS;
        CHR_FF:  char_class = CC_FF;
        default: char_class = CC_IGNORE;
      endcase
    end
  end

endmodule

// File: rtl/lcd_text_buffer.sv
// rtl/lcd_text_buffer.sv - character frame buffer for the SC1602 driver; optional LCD_TEXT_SCROLL_EN
module lcd_text_buffer
  import lcd_text_pkg::*;
#(
  parameter int          COLS      = 16,
  parameter int          ROWS      = 2,
  parameter logic [7:0]  FILL_CHAR = FILL_CHAR_DEFAULT,
  localparam int         N         = COLS * ROWS,
  localparam int         AW        = (N > 1) ? $clog2(N) : 1
)(
  input  logic          sys_clk,
  input  logic          sys_rst_n,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_char,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic [AW-1:0] cursor,
  output logic          busy,
  output logic          dirty,
  input  logic          dirty_clr
);

  localparam int            IW        = (AW < 5) ? 5 : AW;
  localparam logic [AW-1:0] LAST_CELL = AW'(N - 1);
  localparam logic [AW-1:0] LAST_ROW  = AW'(N - COLS);

  lcd_state_e    state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [AW-1:0] cursor_q, cursor_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          dirty_q, dirty_d;
  logic [7:0]    cell_q [N];
  logic [7:0]    cell_d [N];

  char_class_e   char_class;
  logic          accept;
  logic          cell_mod;
  logic [AW-1:0] idx_a;
  logic [AW-1:0] row_start;

  lcd_char_decode u_decode (
    .char_in    (wr_char),
    .char_class (char_class)
  );

  assign wr_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign accept    = wr_valid && wr_ready;
  assign idx_a     = idx_q[AW-1:0];
  assign row_start = AW'((int'(cursor_q) / COLS) * COLS);

  assign rd_data = rd_data_q;
  assign cursor  = cursor_q;
  assign dirty   = dirty_q;

  // Sequencer: character handling in IDLE, one cell per cycle in CLEAR/SCROLL
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cursor_d = cursor_q;
    cell_d   = cell_q;
    cell_mod = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (char_class)
            CC_PRINT: begin
              cell_d[cursor_q] = wr_char;
              cell_mod         = 1'b1;
              if (cursor_q == LAST_CELL) begin
`ifdef LCD_TEXT_SCROLL_EN
                // Character lands first; the scroll then moves it up a row
                state_d = SCROLL;
                idx_d   = '0;
`else
                cursor_d = '0;
`endif
              end else begin
                cursor_d = cursor_q + AW'(1);
              end
            end
            CC_LF: begin
              if (row_start == LAST_ROW) begin
`ifdef LCD_TEXT_SCROLL_EN
                state_d = SCROLL;
                idx_d   = '0;
`else
                cursor_d = '0;
`endif
              end else begin
                cursor_d = row_start + AW'(COLS);
              end
            end
            CC_CR: cursor_d = row_start;
            CC_BS: begin
              if (cursor_q != '0) begin
                cursor_d                 = cursor_q - AW'(1);
                cell_d[cursor_q - AW'(1)] = FILL_CHAR;
                cell_mod                 = 1'b1;
              end
            end
            CC_FF: begin
              state_d = CLEAR;
              idx_d   = '0;
            end
            default: ;
          endcase
        end
      end
      CLEAR: begin
        cell_d[idx_a] = FILL_CHAR;
        cell_mod      = 1'b1;
        if (idx_a == LAST_CELL) begin
          state_d  = IDLE;
          idx_d    = '0;
          cursor_d = '0;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`ifdef LCD_TEXT_SCROLL_EN
      SCROLL: begin
        // Copy phase pulls each row up by one; fill phase blanks the last row
        if (idx_a < LAST_ROW) begin
          cell_d[idx_a] = cell_q[AW'(int'(idx_a) + COLS)];
        end else begin
          cell_d[idx_a] = FILL_CHAR;
        end
        cell_mod = 1'b1;
        if (idx_a == LAST_CELL) begin
          state_d  = IDLE;
          idx_d    = '0;
          cursor_d = LAST_ROW;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
`endif
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Read port samples pre-write contents; dirty set has priority over clear
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) begin
      if (int'(rd_addr) < N) begin
        rd_data_d = cell_q[rd_addr];
      end else begin
        rd_data_d = FILL_CHAR;
      end
    end
    dirty_d = cell_mod || (dirty_q && !dirty_clr);
  end

  // Control and read-port registers
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      cursor_q  <= '0;
      rd_data_q <= 8'h00;
      dirty_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cursor_q  <= cursor_d;
      rd_data_q <= rd_data_d;
      dirty_q   <= dirty_d;
    end
  end

  // Cell array, blanked on reset so the first frame draws as spaces
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      for (int i = 0; i < N; i++) cell_q[i] <= FILL_CHAR;
    end else begin
      for (int i = 0; i < N; i++) cell_q[i] <= cell_d[i];
    end
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// tb/tb_lcd_text_buffer.sv - self-checking bench for lcd_text_buffer; honours LCD_TEXT_SCROLL_EN
module tb_lcd_text_buffer;

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       wr_valid;
  logic       wr_ready;
  logic [7:0] wr_char;
  logic       rd_en;
  logic [4:0] rd_addr;
  logic [7:0] rd_data;
  logic [4:0] cursor;
  logic       busy;
  logic       dirty;
  logic       dirty_clr;

  int nchk = 0;
  int nerr = 0;
  int cyc  = 0;

  typedef struct {
    logic [7:0] ch;
    logic [4:0] addr;
    logic [4:0] exp_cur;
    logic [7:0] exp_cell;
  } vec_t;

  vec_t tbl [14];

  lcd_text_buffer dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_char   (wr_char),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .cursor    (cursor),
    .busy      (busy),
    .dirty     (dirty),
    .dirty_clr (dirty_clr)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_ready();
    int g = 0;
    while (wr_ready !== 1'b1 && g < 200) begin
      @(negedge sys_clk);
      g++;
    end
    if (wr_ready !== 1'b1) chk("wr_ready_timeout", {31'd0, wr_ready}, 32'd1);
  endtask

  task automatic send_char(input logic [7:0] c);
    wait_ready();
    wr_valid = 1'b1;
    wr_char  = c;
    @(negedge sys_clk);
    wr_valid = 1'b0;
  endtask

  task automatic read_cell(input logic [4:0] a, output logic [7:0] d);
    rd_en   = 1'b1;
    rd_addr = a;
    @(negedge sys_clk);
    rd_en = 1'b0;
    d     = rd_data;
  endtask

  initial begin
    logic [7:0] d;
    int c0;

    tbl[0]  = '{8'h46, 5'd0,  5'd1,  8'h46};
    tbl[1]  = '{8'h0A, 5'd0,  5'd16, 8'h46};
    tbl[2]  = '{8'h41, 5'd16, 5'd17, 8'h41};
    tbl[3]  = '{8'h0D, 5'd16, 5'd16, 8'h41};
    tbl[4]  = '{8'h08, 5'd15, 5'd15, 8'h20};
    tbl[5]  = '{8'h08, 5'd14, 5'd14, 8'h20};
    tbl[6]  = '{8'h01, 5'd0,  5'd14, 8'h46};
    tbl[7]  = '{8'hA5, 5'd14, 5'd15, 8'hA5};
    tbl[8]  = '{8'hE0, 5'd15, 5'd15, 8'h20};
    tbl[9]  = '{8'h7F, 5'd15, 5'd15, 8'h20};
    tbl[10] = '{8'h0D, 5'd0,  5'd0,  8'h46};
    tbl[11] = '{8'h08, 5'd0,  5'd0,  8'h46};
    tbl[12] = '{8'h0A, 5'd16, 5'd16, 8'h41};
    tbl[13] = '{8'hDF, 5'd16, 5'd17, 8'hDF};

    sys_rst_n = 1'b0;
    wr_valid  = 1'b0;
    wr_char   = 8'h00;
    rd_en     = 1'b0;
    rd_addr   = '0;
    dirty_clr = 1'b0;
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);

    // Reset state
    chk("rst_cursor", {27'd0, cursor}, 32'd0);
    chk("rst_dirty", {31'd0, dirty}, 32'd1);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'h00);
    for (int i = 0; i < 32; i++) begin
      read_cell(5'(i), d);
      chk($sformatf("rst_cell%0d", i), {24'd0, d}, 32'h20);
    end

    dirty_clr = 1'b1;
    @(negedge sys_clk);
    dirty_clr = 1'b0;
    chk("dirty_cleared", {31'd0, dirty}, 32'd0);

    // Character / control-code vectors
    for (int i = 0; i < 14; i++) begin
      send_char(tbl[i].ch);
      chk($sformatf("vec%0d_cursor", i), {27'd0, cursor}, {27'd0, tbl[i].exp_cur});
      read_cell(tbl[i].addr, d);
      chk($sformatf("vec%0d_cell%0d", i, tbl[i].addr), {24'd0, d}, {24'd0, tbl[i].exp_cell});
    end
    chk("dirty_after_writes", {31'd0, dirty}, 32'd1);

    // dirty_clr coincident with an accepted write: set wins
    dirty_clr = 1'b1;
    @(negedge sys_clk);
    dirty_clr = 1'b0;
    chk("dirty_clr2", {31'd0, dirty}, 32'd0);
    wr_valid  = 1'b1;
    wr_char   = 8'h5A;
    dirty_clr = 1'b1;
    @(negedge sys_clk);
    wr_valid  = 1'b0;
    dirty_clr = 1'b0;
    chk("dirty_set_wins", {31'd0, dirty}, 32'd1);
    chk("cursor_after_z", {27'd0, cursor}, 32'd18);

    // Fill 31 cells with 'A', then clear and time the busy window
    send_char(8'h0C);
    wait_ready();
    chk("clear1_cursor", {27'd0, cursor}, 32'd0);
    for (int i = 0; i < 31; i++) send_char(8'h41);
    chk("fill_cursor", {27'd0, cursor}, 32'd31);
    send_char(8'h0C);
    c0 = cyc;
    chk("clear_ready_low", {31'd0, wr_ready}, 32'd0);
    chk("clear_busy", {31'd0, busy}, 32'd1);
    read_cell(5'd20, d);
    chk("read_during_clear", {24'd0, d}, 32'h41);
    wait_ready();
    chk("clear_busy_cycles", cyc - c0, 32'd32);
    chk("clear_cursor", {27'd0, cursor}, 32'd0);
    for (int i = 0; i < 32; i++) begin
      read_cell(5'(i), d);
      chk($sformatf("clr_cell%0d", i), {24'd0, d}, 32'h20);
    end

    // Same-cycle write is invisible to the read; rd_data then holds
    wr_valid = 1'b1;
    wr_char  = 8'h51;
    rd_en    = 1'b1;
    rd_addr  = 5'd0;
    @(negedge sys_clk);
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    chk("same_cycle_old", {24'd0, rd_data}, 32'h20);
    repeat (3) @(negedge sys_clk);
    chk("rd_hold", {24'd0, rd_data}, 32'h20);
    read_cell(5'd0, d);
    chk("same_cycle_new", {24'd0, d}, 32'h51);

    // 33 printables from a cleared screen: wrap or scroll
    send_char(8'h0C);
    wait_ready();
    for (int i = 0; i < 33; i++) begin
      send_char(8'(8'h30 + i));
`ifdef LCD_TEXT_SCROLL_EN
      if (i == 31) begin
        c0 = cyc;
        chk("scroll_busy", {31'd0, busy}, 32'd1);
        wait_ready();
        chk("scroll_busy_cycles", cyc - c0, 32'd32);
      end
`endif
    end
`ifdef LCD_TEXT_SCROLL_EN
    chk("scroll_cursor", {27'd0, cursor}, 32'd17);
    read_cell(5'd0, d);  chk("scroll_cell0", {24'd0, d}, 32'h40);
    read_cell(5'd15, d); chk("scroll_cell15", {24'd0, d}, 32'h4F);
    read_cell(5'd16, d); chk("scroll_cell16", {24'd0, d}, 32'h50);
    read_cell(5'd17, d); chk("scroll_cell17", {24'd0, d}, 32'h20);
    read_cell(5'd31, d); chk("scroll_cell31", {24'd0, d}, 32'h20);
`else
    chk("wrap_cursor", {27'd0, cursor}, 32'd1);
    read_cell(5'd0, d);  chk("wrap_cell0", {24'd0, d}, 32'h50);
    read_cell(5'd1, d);  chk("wrap_cell1", {24'd0, d}, 32'h31);
    read_cell(5'd31, d); chk("wrap_cell31", {24'd0, d}, 32'h4F);
`endif

    // Reset in the middle of a clear sequence
    send_char(8'h0C);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b0;
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    chk("midrst_ready", {31'd0, wr_ready}, 32'd1);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_cursor", {27'd0, cursor}, 32'd0);
    chk("midrst_dirty", {31'd0, dirty}, 32'd1);
    chk("midrst_rd_data", {24'd0, rd_data}, 32'h00);
    read_cell(5'd20, d);
    chk("midrst_cell20", {24'd0, d}, 32'h20);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/lcd_text_buffer.md
Name: lcd_text_buffer

Overview:
- Character frame buffer feeding the SC1602 LCD driver.
- Upstream user logic streams characters and control codes in through a valid/ready port.
- The buffer keeps a COLS x ROWS cell array with a write cursor.
- The driver reads cells by address through a registered read port and uses the dirty flag to decide when to redraw.

Parameters:
- COLS, 16, characters per row.
- ROWS, 2, number of rows.
- FILL_CHAR, 8'h20, blank character for reset, clear and scroll fill.

Ports:
- sys_clk  in  1  clock.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- wr_valid  in  1  character offered.
- wr_ready  out  1  buffer can accept this cycle.
- wr_char  in  8  character or control code.
- rd_en  in  1  driver read strobe.
- rd_addr  in  AW  cell index, row-major; AW = $clog2(COLS*ROWS).
- rd_data  out  8  cell contents, registered.
- cursor  out  AW  current write position.
- busy  out  1  clear or scroll sequence in progress.
- dirty  out  1  contents changed since last dirty_clr.
- dirty_clr  in  1  driver has consumed the frame.

Behaviour:
- Definitions: N = COLS*ROWS. Storage is a register array, so internal copy reads are combinational.
- Reset values: all cells = FILL_CHAR, cursor = 0, rd_data = 8'h00, wr_ready = 1, busy = 0, dirty = 1 (forces the first draw).
- Reset asserted mid-sequence aborts it and restores all reset values.
- FSM states: IDLE, CLEAR, SCROLL. A 5-bit-or-wider idx counter steps through cells.
  - wr_ready = (state == IDLE).
  - busy = (state != IDLE).
- Accept: a character is accepted when wr_valid && wr_ready.
- Printable codes (0x20-0x7E and 0xA0-0xDF):
  - Write to cell[cursor]; cursor+1.
  - Cursor at N-1 wraps to 0.
- 0x0A newline: cursor moves to the start of the next row; the last row wraps to 0.
- 0x0D carriage return: cursor moves to the start of the current row.
- 0x08 backspace:
  - If cursor != 0: cursor-1 and that cell = FILL_CHAR.
  - At 0: no effect.
- 0x0C clear:
  - Enter CLEAR. Write FILL_CHAR to cell[idx] for idx = 0..N-1, one per cycle (N cycles).
  - Then cursor = 0 and return to IDLE.
- Other codes: accepted and discarded.
- Read port:
  - rd_en at cycle t gives rd_data = cell[rd_addr] at t+1.
  - A same-cycle write is not visible; old data is returned.
  - rd_data holds while rd_en = 0.
  - Reads are serviced in every state.
- dirty:
  - Set the cycle after any cell modification.
  - dirty_clr clears it.
  - If set and clear coincide, set wins.
  - Each CLEAR/SCROLL cell write counts as a modification.
- Out-of-range rd_addr (>= N, non-power-of-two sizes) returns FILL_CHAR.

Optional Feature:
- Macro: LCD_TEXT_SCROLL_EN.
- Defined:
  - A newline on the last row, or a printable write at cell N-1, enters SCROLL instead of wrapping.
  - SCROLL copy phase: idx 0..N-COLS-1 does cell[idx] <= cell[idx+COLS].
  - SCROLL fill phase: idx N-COLS..N-1 does cell[idx] <= FILL_CHAR.
  - Total N cycles; then cursor = N-COLS and return to IDLE.
  - The printable character is written before the scroll starts.
- Undefined: SCROLL state and logic are absent; wrap-to-0 behaviour as above.

Decomposition:
- Package lcd_text_pkg holds:
  - the state enum (IDLE/CLEAR/SCROLL);
  - control code constants CHR_BS = 8'h08, CHR_LF = 8'h0A, CHR_FF = 8'h0C, CHR_CR = 8'h0D;
  - default FILL_CHAR.
- One natural sub-module: lcd_char_decode, combinational. It classifies wr_char into printable/LF/CR/BS/FF/ignore.

Test Plan:
- Reset, then read all 32 addresses -> every rd_data = 8'h20. Also cursor = 0, dirty = 1, wr_ready = 1.
- Write 8'h46, then rd_en with rd_addr 0 -> rd_data = 8'h46 on the next cycle. Also cursor = 1; dirty re-asserts after dirty_clr.
- Write 0x0A then 0x41 -> cell16 = 0x41, cursor = 17. Then 0x0D gives cursor = 16; 0x08 gives cursor = 15 and cell15 = 0x20.
- Fill with 'A', then write 0x0C -> wr_ready low for exactly 32 cycles, all cells 0x20, cursor = 0.
- Write 33 printables '0'..'P' (0x30-0x50):
  - Macro undefined: cell0 = 0x50, cursor = 1.
  - Macro defined: busy for 32 cycles after the 32nd character, row0 = former row1, 33rd character lands at cell16, cursor = 17.
- dirty_clr coincident with an accepted write -> dirty remains 1. A rd_en issued during CLEAR still returns data one cycle later.
